// File: rtl/spi_pkg.sv
//==============================================================================
// spi_pkg : shared constants for the SPI responder            rev 1.0
//==============================================================================
`default_nettype none

package spi_pkg;
  localparam int         BITCNT_W        = 3;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam logic [7:0] IDLE_BYTE_DEF   = 8'hFF;
endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
//==============================================================================
// sync_edge : multi-flop synchronizer with rise/fall detect     rev 1.0
//==============================================================================
`default_nettype none

module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // chain[STAGES-1] is the synchronized level, chain[STAGES] its history.
  logic [STAGES:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {(STAGES + 1){RST_VAL}};
    else        chain <= {chain[STAGES-1:0], d};
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~chain[STAGES];
  assign fall = ~chain[STAGES-1] & chain[STAGES];

endmodule

`default_nettype wire

// File: rtl/spi_target.sv
//==============================================================================
// spi_target : oversampled SPI responder, mode 0/3, one-deep TX hold  rev 1.0
//==============================================================================
`default_nettype none

module spi_target
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       nSS,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sel_start,
  output logic       sel_end,
  output logic       active
);

  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic nss_level, nss_rise, nss_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst_n(nRST), .d(SCK), .q(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst_n(nRST), .d(MOSI), .q(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
    .clk(CLK), .rst_n(nRST), .d(nSS), .q(nss_level), .rise(nss_rise), .fall(nss_fall)
  );

  logic unused_sync;
  assign unused_sync = sck_level ^ mosi_rise ^ mosi_fall ^ nss_level;

  logic [BITCNT_W-1:0] bitcnt;
  logic [7:0]          rx_shift, tx_shift, hold;
  logic                hold_full, fresh;
  logic                load_now;
  logic [7:0]          load_byte;

  // fresh suppresses the mode-3 leading fall so a select consumes hold only once.
  always_comb begin
    load_now  = 1'b0;
    load_byte = hold_full ? hold : IDLE_BYTE;
    if (nss_fall)
      load_now = 1'b1;
    else if (active && !nss_rise && sck_fall && (bitcnt == '0) && !fresh)
      load_now = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bitcnt      <= '0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'hFF;
      hold        <= 8'h00;
      hold_full   <= 1'b0;
      fresh       <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      sel_start   <= 1'b0;
      sel_end     <= 1'b0;
      active      <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      sel_start   <= 1'b0;
      sel_end     <= 1'b0;
      tx_underrun <= load_now && !hold_full;

      if (load_now) hold_full <= 1'b0;
      // A handshake coinciding with a load lands after the load took the old content.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (nss_fall) begin
        active    <= 1'b1;
        sel_start <= 1'b1;
        bitcnt    <= '0;
        fresh     <= 1'b1;
        tx_shift  <= load_byte;
      end else if (nss_rise) begin
        active  <= 1'b0;
        sel_end <= 1'b1;
        bitcnt  <= '0;
        fresh   <= 1'b0;
      end else if (active) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_level};
          bitcnt   <= bitcnt + 1'b1;
          fresh    <= 1'b0;
          if (bitcnt == '1) begin
            rx_data  <= {rx_shift[6:0], mosi_level};
            rx_valid <= 1'b1;
          end
        end else if (sck_fall) begin
          if (bitcnt == '0) begin
            if (!fresh) tx_shift <= load_byte;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b1};
          end
        end
      end
    end
  end

  assign MISO     = tx_shift[7];
  assign MISO_OE  = active;
  assign tx_ready = !hold_full;

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
//==============================================================================
// tb_spi_target : bit-banged host + byte-level reference model   rev 1.0
//==============================================================================
`default_nettype none

module tb_spi_target;

  localparam int H = 8;  // CLK cycles per SCK half period

  logic       CLK = 1'b0, nRST = 1'b0, SCK = 1'b0, MOSI = 1'b0, nSS = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO, MISO_OE, tx_ready, tx_underrun, rx_valid, sel_start, sel_end, active;
  logic [7:0] rx_data;

  spi_target dut (
    .CLK(CLK), .nRST(nRST), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .sel_start(sel_start), .sel_end(sel_end), .active(active)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;

  // Reference model: holding register, byte in the shifter, event counters.
  bit         ref_full  = 1'b0;
  logic [7:0] ref_hold  = 8'h00;
  logic [7:0] ref_shift = 8'hFF;
  int exp_under = 0, exp_rel = 0, exp_ss = 0, exp_se = 0;
  int obs_under = 0, obs_rel = 0, obs_ss = 0, obs_se = 0;

  logic [7:0] exp_rx[$], exp_miso[$], obs_miso[$], mosi_bytes[$];
  bit         mon_en = 1'b0;
  logic       prev_ready = 1'b1;
  logic [7:0] e_rx, e_mi, o_mi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_load();
    if (ref_full) begin
      ref_shift = ref_hold;
      ref_full  = 1'b0;
      exp_rel++;
    end else begin
      ref_shift = 8'hFF;
      exp_under++;
    end
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge CLK);
    check("tx_ready_before_offer", {31'd0, tx_ready}, {31'd0, !ref_full});
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    ref_hold = b;
    ref_full = 1'b1;
  endtask

  task automatic set_idle(input bit cpol);
    if (SCK !== cpol) begin
      @(negedge CLK);
      SCK = cpol;
      ticks(H);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     {31'd0, MISO},        32'd1);
    check({tag, "_miso_oe"},  {31'd0, MISO_OE},     32'd0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready},    32'd1);
    check({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
    check({tag, "_rx_data"},  {24'd0, rx_data},     32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
    check({tag, "_sel"},      {30'd0, sel_start, sel_end}, 32'd0);
    check({tag, "_active"},   {31'd0, active},      32'd0);
  endtask

  // One select window. Bytes come from mosi_bytes; the last byte may be cut short.
  task automatic spi_frame(input bit cpol, input int nbytes, input int nbits_last,
                           input int refill_at, input logic [7:0] refill_val,
                           input int collide, input bit reset_abort);
    logic [7:0] cur, out_byte, obs;
    int bits;
    set_idle(cpol);
    @(negedge CLK);
    nSS = 1'b0;
    model_load();
    exp_ss++;
    if (collide >= 0) begin
      ticks(2);
      tx_data  = collide[7:0];
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
      ref_hold = collide[7:0];
      ref_full = 1'b1;
      ticks(H - 3);
    end else begin
      ticks(H);
    end
    for (int k = 0; k < nbytes; k++) begin
      cur      = mosi_bytes[k];
      bits     = (k == nbytes - 1) ? nbits_last : 8;
      obs      = 8'h00;
      out_byte = 8'h00;
      for (int b = 0; b < bits; b++) begin
        if (cpol) begin
          SCK = 1'b0;
          if (b == 0 && k > 0) model_load();
        end
        if (b == 0) out_byte = ref_shift;
        MOSI = cur[7-b];
        ticks(H);
        obs = {obs[6:0], MISO};
        if (b == 7) exp_rx.push_back(cur);
        SCK = 1'b1;
        ticks(H);
        if (k == refill_at && b == 3 && !ref_full) offer(refill_val);
        if (!cpol) begin
          SCK = 1'b0;
          if (b == 7) model_load();
        end
      end
      if (bits == 8) begin
        exp_miso.push_back(out_byte);
        obs_miso.push_back(obs);
      end
    end
    if (reset_abort) begin
      nRST = 1'b0;
      #1;
      check_reset_outputs("midbyte_reset");
      if (ref_full) exp_rel++;
      ref_full  = 1'b0;
      ref_shift = 8'hFF;
      SCK = 1'b0;
      nSS = 1'b1;
      ticks(2);
      nRST = 1'b1;
      ticks(H);
    end else begin
      ticks(H);
      nSS = 1'b1;
      exp_se++;
      ticks(2 * H);
    end
  endtask

  task automatic scenario_check(input string tag);
    ticks(4);
    check({tag, "_rx_pending"},   exp_rx.size(),   32'd0);
    check({tag, "_miso_pending"}, exp_miso.size(), 32'd0);
    check({tag, "_underruns"},    obs_under,       exp_under);
    check({tag, "_hold_consumed"}, obs_rel,        exp_rel);
    check({tag, "_sel_starts"},   obs_ss,          exp_ss);
    check({tag, "_sel_ends"},     obs_se,          exp_se);
    check({tag, "_tx_ready"},     {31'd0, tx_ready}, {31'd0, !ref_full});
    check({tag, "_miso_oe_idle"}, {31'd0, MISO_OE}, 32'd0);
  endtask

  // Monitor: received bytes, event pulses, MISO bytes captured by the host.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rx_valid_unexpected: got rx_data %0h, expected no pulse", rx_data);
        end else begin
          e_rx = exp_rx.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e_rx});
        end
      end
      if (tx_underrun) obs_under++;
      if (sel_start)   obs_ss++;
      if (sel_end)     obs_se++;
      if (tx_ready && !prev_ready) obs_rel++;
      if (obs_miso.size() > 0 && exp_miso.size() > 0) begin
        o_mi = obs_miso.pop_front();
        e_mi = exp_miso.pop_front();
        check("miso_byte", {24'd0, o_mi}, {24'd0, e_mi});
      end
    end
    prev_ready = tx_ready;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, nl, ra;
    bit cp;
    ticks(3);
    check_reset_outputs("por");
    nRST = 1'b1;
    ticks(4);
    mon_en = 1'b1;

    // Mode 0, A5 out / 3C in; a second byte is queued so the trailing fall finds one.
    offer(8'hA5);
    mosi_bytes = '{8'h3C};
    spi_frame(1'b0, 1, 8, 0, 8'h11, -1, 1'b0);
    check("mode0_no_underrun", obs_under, 32'd0);
    scenario_check("mode0");

    // Mode 3, same stimulus.
    offer(8'hA5);
    spi_frame(1'b1, 1, 8, -1, 8'h00, -1, 1'b0);
    scenario_check("mode3");

    // Back-to-back bytes, refilled after the first load, then without refill.
    offer(8'h11);
    mosi_bytes = '{8'h22, 8'h33};
    spi_frame(1'b1, 2, 8, 0, 8'h5A, -1, 1'b0);
    scenario_check("b2b_refill");
    offer(8'h11);
    spi_frame(1'b1, 2, 8, -1, 8'h00, -1, 1'b0);
    scenario_check("b2b_underrun");

    // Deselect after 5 SCK periods, then a clean frame.
    mosi_bytes = '{8'hE7};
    spi_frame(1'b0, 1, 5, -1, 8'h00, -1, 1'b0);
    mosi_bytes = '{8'h81};
    spi_frame(1'b0, 1, 8, -1, 8'h00, -1, 1'b0);
    scenario_check("abort_nss");

    // Reset mid-byte, then a clean frame.
    offer(8'h6B);
    mosi_bytes = '{8'h99};
    spi_frame(1'b0, 1, 4, -1, 8'h00, -1, 1'b1);
    mosi_bytes = '{8'hC3};
    spi_frame(1'b0, 1, 8, -1, 8'h00, -1, 1'b0);
    scenario_check("reset_abort");

    // Handshake in the same cycle as the select load with hold empty.
    mosi_bytes = '{8'h4D, 8'hB2};
    spi_frame(1'b0, 2, 8, -1, 8'h00, 8'h77, 1'b0);
    scenario_check("collide");

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      cp = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 3));
      nl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      ra = int'($urandom_range(0, nb)) - 1;
      mosi_bytes.delete();
      for (int k = 0; k < nb; k++) mosi_bytes.push_back(8'($urandom));
      if (!ref_full && $urandom_range(0, 1) == 1) offer(8'($urandom));
      spi_frame(cp, nb, nl, ra, 8'($urandom), -1, 1'b0);
    end
    scenario_check("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
